bcd_hex_display: RTL and testbench
==================================

# bcd_hex_display

Sequential binary-to-BCD converter and multi-digit seven-segment driver for the board's HEX displays. It accepts a `WIDTH`-bit unsigned value over a valid/ready handshake and converts it with shift-and-add-3, one bit per clock. It then drives `DIGITS` active-low seven-segment codes. It also provides overflow indication with dash display and optional leading-zero blanking. It supersedes the fixed 4-bit switch comparator/decoder pair for all multi-digit numeric readouts.

## Interface
- `WIDTH`, 8, width of the binary input; legal range 1..32.
- `DIGITS`, 3, number of displayed decimal digits; legal range 1..8.

- `CLOCK_50`  in  1  system clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `value` is valid this cycle.
- `in_ready`  out  1  block idle and able to accept; high exactly when state is IDLE.
- `value`  in  `WIDTH`  unsigned binary input.
- `blank_lz`  in  1  leading-zero blanking enable; sampled with `value`.
- `done`  out  1  one-cycle pulse when new results appear on the outputs.
- `overflow`  out  1  last accepted value exceeded 10^`DIGITS`−1.
- `bcd`  out  4*`DIGITS`  packed BCD result; digit k in bits [4k+3:4k]; digit 0 is the least significant.
- `HEX`  out  7*`DIGITS`  segment codes; digit k in bits [7k+6:7k], bit order {g,f,e,d,c,b,a}, active-low.

## Operation
- Transfer occurs on a rising edge with `in_valid` && `in_ready`. At that edge the block captures `value`, `blank_lz`, and the overflow flag (`value` > 10^`DIGITS`−1, compared against an elaboration-time constant).
- FSM states:
  - IDLE → CONV on transfer. The internal shift register is loaded with binary = `value` and BCD = 0, and the bit counter is set to `WIDTH`.
  - CONV: each edge, 3 is added to every internal BCD nibble ≥ 5, then the combined {BCD, binary} register shifts left by one and the counter decrements. After the `WIDTH`-th shift the FSM goes to UPDATE.
  - UPDATE → IDLE unconditionally. Output registers load on this edge and `done` is asserted for the following cycle.
- The internal BCD register holds ceil(`WIDTH`/3)+1 digits, which is never truncated. Only the low `DIGITS` digits go to `bcd`.
- Segment encoding per digit:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - dash = 0111111
  - blank = 1111111
- When overflow is set, every `HEX` digit shows dash. `bcd` still carries the low `DIGITS` digits of the true result.
- When `blank_lz` is set and there is no overflow, each digit above the most significant nonzero digit shows blank. Digit 0 is never blanked, so value 0 shows "0".
- `in_valid` while not IDLE is ignored; there is no queueing.
- `bcd`, `HEX` and `overflow` hold their previous values throughout CONV and UPDATE until the UPDATE edge.

## Timing
- Reset (async assert, synchronous-safe deassert handled upstream) sets:
  - state IDLE, `in_ready`=1
  - `done`=0, `overflow`=0
  - `bcd`=0, every `HEX` digit = blank (1111111)
- Latency: transfer at edge T; shifts at edges T+1..T+`WIDTH`; UPDATE edge T+`WIDTH`+1. Outputs and `done`=1 are valid after edge T+`WIDTH`+1, and `done` returns to 0 after edge T+`WIDTH`+2.
- `in_ready` is low after edge T and high again after edge T+`WIDTH`+1. A new transfer may occur at edge T+`WIDTH`+2, giving a throughput of one value per `WIDTH`+2 cycles.
- When `WIDTH`=1, CONV lasts exactly one edge.
- `resetn` asserted mid-CONV or mid-UPDATE aborts the conversion immediately. All outputs take their reset values, `done` never fires for the aborted value, and `in_ready`=1 once reset is released.
- `value` and `blank_lz` need only be stable at the transfer edge.

## Test plan
- Defaults. Transfer `value`=255, `blank_lz`=0 at edge T. Required: `done` high only in the cycle after edge T+9, `bcd`=0x255, HEX2=0100100, HEX1=0010010, HEX0=0010010, `overflow`=0.
- `blank_lz`=1, `value`=7. Required: HEX2=HEX1=1111111, HEX0=1111000, `bcd`=0x007. Repeat with `value`=0; required: HEX0=1000000, upper digits blank.
- `DIGITS`=2, `WIDTH`=8, `value`=100. Required: `overflow`=1, both digits 0111111, `bcd`=0x00. With `value`=99, required: `overflow`=0, `bcd`=0x99.
- Busy handling. Hold `in_valid`=1 continuously with `value` changing 12→34→56. Required: only values present at the IDLE edges are accepted, transfers are spaced 10 cycles apart, and each `done` shows the matching BCD.
- Reset mid-operation. Assert `resetn`=0 at edge T+4 of a conversion of 200. Required: `HEX` immediately all 1111111, `bcd`=0, no `done` pulse, and `in_ready`=1 after release.
- `WIDTH`=16, `DIGITS`=5, `value`=65535. Required: `bcd`=0x65535, `done` after edge T+17, `overflow`=0.

Source files
------------

// File: rtl/bcd_hex_display_if.sv
// =====================================================================
// bcd_hex_display_if: value handshake and display result bundle  Rev 1.0
// =====================================================================
`default_nettype none

interface bcd_hex_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      value;
  logic                  blank_lz;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   HEX;

  modport master (
    output in_valid, value, blank_lz,
    input  in_ready, done, overflow, bcd, HEX
  );

  modport slave (
    input  in_valid, value, blank_lz,
    output in_ready, done, overflow, bcd, HEX
  );
endinterface

`default_nettype wire

// File: rtl/bcd_hex_display.sv
// =====================================================================
// bcd_hex_display: serial binary-to-BCD + active-low 7-seg driver  Rev 1.0
// =====================================================================
`default_nettype none

module bcd_hex_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  bcd_hex_display_if.slave     bus
);

  localparam int c_NREQ = (WIDTH + 2) / 3 + 1;
  localparam int c_NI   = (c_NREQ > DIGITS) ? c_NREQ : DIGITS;
  localparam int c_SW   = 4 * c_NI + WIDTH;
  localparam int c_CW   = $clog2(WIDTH + 1);

  localparam logic [6:0] c_BLANK = 7'b1111111;
  localparam logic [6:0] c_DASH  = 7'b0111111;

  function automatic logic [63:0] f_pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] c_MAX = f_pow10(DIGITS) - 64'd1;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = c_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_SW-1:0]      r_shift;
  logic [c_CW-1:0]      r_cnt;
  logic                 r_blank;
  logic                 r_ovf_cap;
  logic                 r_ready;
  logic                 r_done;
  logic                 r_ovf;
  logic [4*DIGITS-1:0]  r_bcd;
  logic [7*DIGITS-1:0]  r_hex;

  logic [c_SW-1:0]      w_adj;
  logic [4*DIGITS-1:0]  w_bcd;
  logic [7*DIGITS-1:0]  w_hex;
  logic [63:0]          w_val64;
  logic                 w_ovf;
  logic                 w_seen;

  assign w_val64 = {{(64-WIDTH){1'b0}}, bus.value};
  assign w_ovf   = (w_val64 > c_MAX);

  // Register layout is {BCD digits, binary}; BCD nibbles sit above the binary part.
  always_comb begin
    w_adj = r_shift;
    for (int k = 0; k < c_NI; k++) begin
      if (r_shift[WIDTH+4*k +: 4] >= 4'd5)
        w_adj[WIDTH+4*k +: 4] = r_shift[WIDTH+4*k +: 4] + 4'd3;
    end
  end

  assign w_bcd = r_shift[WIDTH +: 4*DIGITS];

  // Scan from the top digit down so w_seen marks the first nonzero digit.
  always_comb begin
    w_hex  = '1;
    w_seen = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (w_bcd[4*k +: 4] != 4'd0) w_seen = 1'b1;
      if (r_ovf_cap)
        w_hex[7*k +: 7] = c_DASH;
      else if (r_blank && !w_seen && (k != 0))
        w_hex[7*k +: 7] = c_BLANK;
      else
        w_hex[7*k +: 7] = f_seg(w_bcd[4*k +: 4]);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_blank   <= 1'b0;
      r_ovf_cap <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_bcd     <= '0;
      r_hex     <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_shift   <= {{(4*c_NI){1'b0}}, bus.value};
            r_cnt     <= c_CW'(WIDTH);
            r_blank   <= bus.blank_lz;
            r_ovf_cap <= w_ovf;
            r_ready   <= 1'b0;
            r_state   <= S_CONV;
          end
        end
        S_CONV: begin
          r_shift <= {w_adj[c_SW-2:0], 1'b0};
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == c_CW'(1)) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_bcd   <= w_bcd;
          r_hex   <= w_hex;
          r_ovf   <= r_ovf_cap;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = r_ready;
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;
  assign bus.bcd      = r_bcd;
  assign bus.HEX      = r_hex;

endmodule

`default_nettype wire

// File: tb/tb_bcd_hex_display.sv
// =====================================================================
// tb_bcd_hex_display: bench for three bcd_hex_display configurations  Rev 1.0
// =====================================================================
`default_nettype none

module tb_bcd_hex_display;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   nchk   = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  bcd_hex_display_if #(.WIDTH(8),  .DIGITS(3)) ia ();
  bcd_hex_display_if #(.WIDTH(8),  .DIGITS(2)) ib ();
  bcd_hex_display_if #(.WIDTH(16), .DIGITS(5)) ic ();

  bcd_hex_display #(.WIDTH(8),  .DIGITS(3)) u_a (.CLOCK_50(clk), .resetn(resetn), .bus(ia));
  bcd_hex_display #(.WIDTH(8),  .DIGITS(2)) u_b (.CLOCK_50(clk), .resetn(resetn), .bus(ib));
  bcd_hex_display #(.WIDTH(16), .DIGITS(5)) u_c (.CLOCK_50(clk), .resetn(resetn), .bus(ic));

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Decimal digits by repeated division; display rules applied per digit.
  function automatic void model(input longint v, input bit blz, input int nd,
                                output logic [31:0] eb, output logic [55:0] eh, output bit eo);
    longint     t;
    longint     lim;
    int         msd;
    logic [3:0] d [8];
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    eo  = (v >= lim);
    t   = v;
    msd = 0;
    eb  = '0;
    eh  = '0;
    for (int k = 0; k < nd; k++) begin
      d[k] = 4'(t % 10);
      t    = t / 10;
      eb[4*k +: 4] = d[k];
      if (d[k] != 4'd0) msd = k;
    end
    for (int k = 0; k < nd; k++) begin
      if (eo)                   eh[7*k +: 7] = 7'b0111111;
      else if (blz && k > msd)  eh[7*k +: 7] = 7'b1111111;
      else                      eh[7*k +: 7] = seg_tab[d[k]];
    end
  endfunction

  int          m_busy  = 0;
  logic [7:0]  m_v     = '0;
  bit          m_blz   = 1'b0;
  logic [31:0] m_bcd   = '0;
  logic [55:0] m_hex   = '1;
  bit          m_ovf   = 1'b0;
  bit          m_done  = 1'b0;
  bit          m_ready = 1'b1;

  // Transaction-level model of configuration A: busy for WIDTH+1 edges after a transfer.
  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_busy = 0; m_bcd = '0; m_hex = '1; m_ovf = 1'b0; m_done = 1'b0; m_ready = 1'b1;
    end else if (m_busy == 0) begin
      m_done = 1'b0;
      if (ia.in_valid) begin
        m_v = ia.value; m_blz = ia.blank_lz; m_busy = 9; m_ready = 1'b0;
      end
    end else begin
      m_busy--;
      m_done = (m_busy == 0);
      if (m_busy == 0) begin
        model(longint'(m_v), m_blz, 3, m_bcd, m_hex, m_ovf);
        m_ready = 1'b1;
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("a_ready", 64'(ia.in_ready), 64'(m_ready));
      chk("a_done",  64'(ia.done),     64'(m_done));
      chk("a_ovf",   64'(ia.overflow), 64'(m_ovf));
      chk("a_bcd",   64'(ia.bcd),      64'(m_bcd[11:0]));
      chk("a_hex",   64'(ia.HEX),      64'(m_hex[20:0]));
    end
  end

  task automatic wait_done_a(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ia.done && n < 100);
  endtask

  task automatic xfer_a(input logic [7:0] v, input bit blz, output int lat);
    int n = 0;
    @(negedge clk);
    while (!ia.in_ready && n < 100) begin @(negedge clk); n++; end
    ia.in_valid = 1'b1; ia.value = v; ia.blank_lz = blz;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    wait_done_a(lat);
  endtask

  task automatic xfer_b(input logic [7:0] v, input bit blz, output int lat);
    int n = 0;
    @(negedge clk);
    while (!ib.in_ready && n < 100) begin @(negedge clk); n++; end
    ib.in_valid = 1'b1; ib.value = v; ib.blank_lz = blz;
    @(posedge clk); #1;
    ib.in_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ib.done && lat < 100);
  endtask

  task automatic xfer_c(input logic [15:0] v, input bit blz, output int lat);
    int n = 0;
    @(negedge clk);
    while (!ic.in_ready && n < 100) begin @(negedge clk); n++; end
    ic.in_valid = 1'b1; ic.value = v; ic.blank_lz = blz;
    @(posedge clk); #1;
    ic.in_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ic.done && lat < 100);
  endtask

  initial begin
    int          lat;
    int          n;
    logic [31:0] eb;
    logic [55:0] eh;
    bit          eo;

    ia.in_valid = 1'b0; ia.value = '0; ia.blank_lz = 1'b0;
    ib.in_valid = 1'b0; ib.value = '0; ib.blank_lz = 1'b0;
    ic.in_valid = 1'b0; ic.value = '0; ic.blank_lz = 1'b0;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    chk("rst_a_hex",   64'(ia.HEX),      64'h1FFFFF);
    chk("rst_a_bcd",   64'(ia.bcd),      64'h0);
    chk("rst_a_ready", 64'(ia.in_ready), 64'h1);
    chk("rst_a_done",  64'(ia.done),     64'h0);
    chk("rst_a_ovf",   64'(ia.overflow), 64'h0);
    chk("rst_b_hex",   64'(ib.HEX),      64'h3FFF);
    chk("rst_c_hex",   64'(ic.HEX),      64'h7_FFFF_FFFF);

    xfer_a(8'd255, 1'b0, lat);
    chk("a255_lat", 64'(lat), 64'd9);
    chk("a255_bcd", 64'(ia.bcd), 64'h255);
    chk("a255_hex", 64'(ia.HEX), 64'({7'b0100100, 7'b0010010, 7'b0010010}));
    chk("a255_ovf", 64'(ia.overflow), 64'h0);
    @(posedge clk); #1;
    chk("a255_done_drop", 64'(ia.done), 64'h0);

    xfer_a(8'd7, 1'b1, lat);
    chk("a7lz_bcd", 64'(ia.bcd), 64'h007);
    chk("a7lz_hex", 64'(ia.HEX), 64'({7'b1111111, 7'b1111111, 7'b1111000}));
    xfer_a(8'd0, 1'b1, lat);
    chk("a0lz_hex", 64'(ia.HEX), 64'({7'b1111111, 7'b1111111, 7'b1000000}));
    xfer_a(8'd0, 1'b0, lat);
    chk("a0_hex", 64'(ia.HEX), 64'({7'b1000000, 7'b1000000, 7'b1000000}));
    xfer_a(8'd100, 1'b1, lat);
    chk("a100lz_hex", 64'(ia.HEX), 64'({7'b1111001, 7'b1000000, 7'b1000000}));

    // in_valid held high while value changes during conversions
    @(negedge clk);
    n = 0;
    while (!ia.in_ready && n < 100) begin @(negedge clk); n++; end
    ia.in_valid = 1'b1; ia.value = 8'd12; ia.blank_lz = 1'b0;
    @(posedge clk); #1;
    ia.value = 8'd34;
    wait_done_a(n);
    chk("busy12_lat", 64'(n), 64'd9);
    chk("busy12_bcd", 64'(ia.bcd), 64'h012);
    @(posedge clk); #1;
    ia.value = 8'd56;
    wait_done_a(n);
    chk("busy34_gap", 64'(n + 1), 64'd10);
    chk("busy34_bcd", 64'(ia.bcd), 64'h034);
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    wait_done_a(n);
    chk("busy56_gap", 64'(n + 1), 64'd10);
    chk("busy56_bcd", 64'(ia.bcd), 64'h056);

    // reset asserted just after edge T+4 of a conversion of 200
    @(negedge clk);
    ia.in_valid = 1'b1; ia.value = 8'd200; ia.blank_lz = 1'b0;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_hex",  64'(ia.HEX),  64'h1FFFFF);
    chk("mid_rst_bcd",  64'(ia.bcd),  64'h0);
    chk("mid_rst_done", 64'(ia.done), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    chk("mid_rst_ready", 64'(ia.in_ready), 64'h1);
    n = 0;
    repeat (15) begin @(posedge clk); #1; if (ia.done) n++; end
    chk("mid_rst_nodone", 64'(n), 64'd0);

    xfer_b(8'd100, 1'b0, lat);
    chk("b100_ovf", 64'(ib.overflow), 64'h1);
    chk("b100_hex", 64'(ib.HEX), 64'({7'b0111111, 7'b0111111}));
    chk("b100_bcd", 64'(ib.bcd), 64'h00);
    xfer_b(8'd99, 1'b0, lat);
    chk("b99_ovf", 64'(ib.overflow), 64'h0);
    chk("b99_bcd", 64'(ib.bcd), 64'h99);
    chk("b99_hex", 64'(ib.HEX), 64'({7'b0010000, 7'b0010000}));
    xfer_b(8'd255, 1'b1, lat);
    model(64'd255, 1'b1, 2, eb, eh, eo);
    chk("b255_ovf", 64'(ib.overflow), 64'(eo));
    chk("b255_bcd", 64'(ib.bcd), 64'(eb[7:0]));
    chk("b255_hex", 64'(ib.HEX), 64'(eh[13:0]));

    xfer_c(16'd65535, 1'b0, lat);
    chk("c65535_lat", 64'(lat), 64'd17);
    chk("c65535_bcd", 64'(ic.bcd), 64'h65535);
    chk("c65535_ovf", 64'(ic.overflow), 64'h0);
    chk("c65535_hex", 64'(ic.HEX),
        64'({7'b0000010, 7'b0010010, 7'b0010010, 7'b0110000, 7'b0010010}));
    xfer_c(16'd1000, 1'b1, lat);
    chk("c1000lz_hex", 64'(ic.HEX),
        64'({7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000}));
    xfer_c(16'd4093, 1'b1, lat);
    model(64'd4093, 1'b1, 5, eb, eh, eo);
    chk("c4093_bcd", 64'(ic.bcd), 64'(eb[19:0]));
    chk("c4093_hex", 64'(ic.HEX), 64'(eh[34:0]));

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

`default_nettype wire
